// File: rtl/fetch_unit_if.sv
// fetch_unit bus bundle: instruction-memory port, decode handshake
// and redirect/halt sideband. master = fetch stage, slave = its peers.
interface fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [15:0]       imem_rdata;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_pc2;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output instr, instr_pc, instr_pc2, instr_valid,
        input  instr_ready, redirect, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  instr, instr_pc, instr_pc2, instr_valid,
        output instr_ready, redirect, redirect_pc,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem
// request at a time and holds the fetched word until decode takes it.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] STOP  = 2'd2;

    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(1);
    localparam logic [3:0]        OP_HALT = 4'hF;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ipc_q;
    logic [ADDR_W-1:0] ipc2_q;
    logic [15:0]       instr_q;
    logic              req_q;
    logic              ivalid_q;
    logic              halted_q;
    logic              resp;
    logic              consume;
    logic              issue;

    // Event decode: response to the pending request, buffer consume, issue slot.
    always_comb begin
        resp    = req_q && bus.imem_valid;
        consume = ivalid_q && bus.instr_ready;
        issue   = !req_q && (!ivalid_q || bus.instr_ready);
    end

    // PC, request, output buffer and FSM; redirect overrides every other event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= '0;
            ipc_q    <= '0;
            ipc2_q   <= '0;
            ivalid_q <= 1'b0;
            halted_q <= 1'b0;
        end else if (bus.redirect) begin
            pc       <= bus.redirect_pc & ALIGN;
            ivalid_q <= 1'b0;
            if (req_q && !bus.imem_valid) begin
                state <= DRAIN;
            end else begin
                req_q <= 1'b0;
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (resp) begin
                        instr_q  <= bus.imem_rdata;
                        ipc_q    <= pc;
                        ipc2_q   <= pc + TWO;
                        ivalid_q <= 1'b1;
                        pc       <= pc + TWO;
                        req_q    <= 1'b0;
                        if (bus.imem_rdata[15:12] == OP_HALT) begin
                            state <= STOP;
                        end
                    end else begin
                        if (consume) begin
                            ivalid_q <= 1'b0;
                        end
                        if (issue) begin
                            req_q  <= 1'b1;
                            addr_q <= pc;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.imem_valid) begin
                        req_q <= 1'b0;
                        state <= FETCH;
                    end
                end
                STOP: begin
                    if (consume) begin
                        ivalid_q <= 1'b0;
                        halted_q <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_pc2   = ipc2_q;
    assign bus.instr_valid = ivalid_q;
    assign bus.halted      = halted_q;
endmodule
